// File: rtl/amadeus_pkg.sv
// -----------------------------------------------------------------------------
// amadeus_pkg
//   Shared types for the convolution layer controllers: operating mode, the
//   op_stage code broadcast to the PE array, and the layer sequencer states.
//   Also provides the mode -> ofmap size lookup and the state -> op_stage map.
//   The L*_OFMAP_SIZE defaults apply only when the global defines header has
//   not already provided them (each size must be <= 64).
//   Optional feature macro used by the controller: CONV_TIMEOUT_EN.
// -----------------------------------------------------------------------------
`ifndef L1_OFMAP_SIZE
`define L1_OFMAP_SIZE 16
`endif
`ifndef L2_OFMAP_SIZE
`define L2_OFMAP_SIZE 8
`endif
`ifndef L3_OFMAP_SIZE
`define L3_OFMAP_SIZE 4
`endif

package amadeus_pkg;

    typedef enum logic [1:0] {
        MODE1 = 2'd0,
        MODE2 = 2'd1,
        MODE3 = 2'd2,
        MODE4 = 2'd3
    } op_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CONV = 2'd2
    } op_stage_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_LOAD,
        S_CONV,
        S_NEXT,
        S_DONE
    } ctrl_state_t;

    localparam int unsigned PSUM_IDX_W = 6;

    // Index of the last ofmap position for a layer mode.
    function automatic logic [PSUM_IDX_W-1:0] ofmap_max_of(input op_mode_t m);
        case (m)
            MODE1, MODE2: return PSUM_IDX_W'(`L1_OFMAP_SIZE - 1);
            MODE3:        return PSUM_IDX_W'(`L2_OFMAP_SIZE - 1);
            default:      return PSUM_IDX_W'(`L3_OFMAP_SIZE - 1);
        endcase
    endfunction

    // S_NEXT and S_DONE are short tails of the CONV phase, so they keep
    // reporting CONV; S_CFG has not started loading yet and reports IDLE.
    function automatic op_stage_t stage_of(input ctrl_state_t s);
        case (s)
            S_LOAD:                 return LOAD;
            S_CONV, S_NEXT, S_DONE: return CONV;
            default:                return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/conv_psum_counter.sv
// -----------------------------------------------------------------------------
// conv_psum_counter
//   Counts psum packets of one input-channel pass: filter_idx (0..3) advances
//   on every inc, psum_idx advances when filter_idx wraps 3 -> 0.
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     inc         one packet accepted
//     clr         synchronous clear of both indices (wins over inc)
//     ofmap_max   last ofmap position index of the current mode
//     last_pkt    current packet slot is the final one of the pass
// -----------------------------------------------------------------------------
module conv_psum_counter
    import amadeus_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  clr,
    input  logic [PSUM_IDX_W-1:0] ofmap_max,
    output logic                  last_pkt
);

    logic [1:0]            filter_idx;
    logic [PSUM_IDX_W-1:0] psum_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filter_idx <= '0;
            psum_idx   <= '0;
        end else if (clr) begin
            filter_idx <= '0;
            psum_idx   <= '0;
        end else if (inc) begin
            filter_idx <= filter_idx + 2'd1;
            if (filter_idx == 2'd3) begin
                psum_idx <= psum_idx + 1'b1;
            end
        end
    end

    assign last_pkt = (filter_idx == 2'd3) && (psum_idx == ofmap_max);

endmodule

// File: rtl/conv_sched_ctrl.sv
// -----------------------------------------------------------------------------
// conv_sched_ctrl
//   Layer sequencer for one convolution layer on the PE array. Latches the
//   layer mode and pass count on start, walks CFG -> LOAD -> CONV per
//   input-channel pass, pulses conv_continue between passes and done at the end.
//   Optional macro CONV_TIMEOUT_EN: idle watchdog in CONV (TIMEOUT_CYC cycles
//   without psum_ack aborts the layer and pulses timeout_err).
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     start           layer start request (ignored while busy)
//     abort           synchronous abort to IDLE (wins over start)
//     mode_cfg        layer mode, sampled on accepted start
//     pass_num        input-channel passes (0 treated as 1), sampled on start
//     load_done       current pass chunk loaded (used in LOAD only)
//     psum_ack        one psum packet accepted downstream (counted in CONV only)
//     mode_out        registered layer mode
//     change_mode     1-cycle pulse, mode_out valid
//     conv_continue   1-cycle pulse between passes
//     op_stage        IDLE / LOAD / CONV
//     pass_idx        current pass, 0-based
//     busy            controller not idle
//     done            1-cycle pulse, layer complete
//     timeout_err     1-cycle watchdog pulse (0 unless CONV_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module conv_sched_ctrl
    import amadeus_pkg::*;
#(
    parameter int unsigned PASS_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  op_mode_t          mode_cfg,
    input  logic [PASS_W-1:0] pass_num,
    input  logic              load_done,
    input  logic              psum_ack,
    output op_mode_t          mode_out,
    output logic              change_mode,
    output logic              conv_continue,
    output op_stage_t         op_stage,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    ctrl_state_t       state;
    ctrl_state_t       state_nxt;
    logic [PASS_W-1:0] pass_last;
    logic              start_acc;
    logic              cnt_inc;
    logic              cnt_clr;
    logic              last_pkt;
    logic              timeout_hit;

    assign start_acc = (state == S_IDLE) && start && !abort;
    assign cnt_inc   = (state == S_CONV) && psum_ack;
    // Indices only live inside CONV; leaving it (pass end, done, abort) clears them.
    assign cnt_clr   = (state != S_CONV) || abort;

    conv_psum_counter u_psum_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (cnt_inc),
        .clr       (cnt_clr),
        .ofmap_max (ofmap_max_of(mode_out)),
        .last_pkt  (last_pkt)
    );

`ifdef CONV_TIMEOUT_EN
    logic [15:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if ((state != S_CONV) || psum_ack) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == S_CONV) && !psum_ack && !abort &&
                         (idle_cnt == 16'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_CFG;
            S_CFG:  state_nxt = S_LOAD;
            S_LOAD: if (load_done) state_nxt = S_CONV;
            S_CONV: begin
                if (psum_ack && last_pkt) begin
                    state_nxt = (pass_idx < pass_last) ? S_NEXT : S_DONE;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_NEXT: state_nxt = S_LOAD;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Outputs are registered from the next state so every pulse lines up
    // exactly with the cycle the FSM spends in the corresponding state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            mode_out      <= MODE1;
            pass_last     <= '0;
            pass_idx      <= '0;
            op_stage      <= IDLE;
            busy          <= 1'b0;
            change_mode   <= 1'b0;
            conv_continue <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_nxt;
            op_stage      <= stage_of(state_nxt);
            busy          <= (state_nxt != S_IDLE);
            change_mode   <= (state_nxt == S_CFG);
            conv_continue <= (state_nxt == S_NEXT);
            done          <= (state_nxt == S_DONE);
            timeout_err   <= timeout_hit;
            if (start_acc) begin
                mode_out  <= mode_cfg;
                pass_last <= (pass_num == '0) ? '0 : pass_num - 1'b1;
            end
            if (state_nxt == S_IDLE) begin
                pass_idx <= '0;
            end else if (state_nxt == S_NEXT) begin
                pass_idx <= pass_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_sched_ctrl.sv
`ifndef L1_OFMAP_SIZE
`define L1_OFMAP_SIZE 16
`endif
`ifndef L2_OFMAP_SIZE
`define L2_OFMAP_SIZE 8
`endif
`ifndef L3_OFMAP_SIZE
`define L3_OFMAP_SIZE 4
`endif

module tb_conv_sched_ctrl;
    import amadeus_pkg::*;

    localparam int unsigned PW = 4;
    localparam int          TO = 16;
`ifdef CONV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, load_done, psum_ack;
    op_mode_t      mode_cfg;
    logic [PW-1:0] pass_num;
    op_mode_t      mode_out;
    logic          change_mode, conv_continue, busy, done, timeout_err;
    op_stage_t     op_stage;
    logic [PW-1:0] pass_idx;

    always #5 clk = ~clk;

    conv_sched_ctrl #(.PASS_W(PW), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .mode_cfg      (mode_cfg),
        .pass_num      (pass_num),
        .load_done     (load_done),
        .psum_ack      (psum_ack),
        .mode_out      (mode_out),
        .change_mode   (change_mode),
        .conv_continue (conv_continue),
        .op_stage      (op_stage),
        .pass_idx      (pass_idx),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err)
    );

    // ---------------- reference model (layer-level bookkeeping) ----------------
    typedef enum {PH_IDLE, PH_CFG, PH_LOAD, PH_CONV, PH_NEXT, PH_DONE} ph_t;
    ph_t      ph;
    op_mode_t m_mode;
    int       m_passes, m_pidx, m_acks, m_idle;
    bit       e_chg, e_cont, e_done, e_to;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_chg, n_cont, n_done, n_to, n_load, last_ack_cyc, done_cyc, pidx_mask;
    bit prev_load;

    function automatic int pkts(input op_mode_t m);
        case (m)
            MODE1, MODE2: return 4 * `L1_OFMAP_SIZE;
            MODE3:        return 4 * `L2_OFMAP_SIZE;
            default:      return 4 * `L3_OFMAP_SIZE;
        endcase
    endfunction

    task automatic model_reset();
        ph = PH_IDLE; m_mode = MODE1; m_passes = 1;
        m_pidx = 0; m_acks = 0; m_idle = 0;
        e_chg = 0; e_cont = 0; e_done = 0; e_to = 0;
    endtask

    task automatic model_clock(input bit st, ab, input op_mode_t m, input int pn,
                               input bit ld, ack);
        e_chg = 0; e_cont = 0; e_done = 0; e_to = 0;
        if (ab) begin
            ph = PH_IDLE; m_pidx = 0; m_acks = 0;
        end else begin
            case (ph)
                PH_IDLE: if (st) begin
                    m_mode = m; m_passes = (pn % 16 == 0) ? 1 : pn % 16;
                    ph = PH_CFG; e_chg = 1;
                end
                PH_CFG:  ph = PH_LOAD;
                PH_LOAD: if (ld) begin ph = PH_CONV; m_idle = 0; end
                PH_CONV: begin
                    if (ack) begin
                        m_idle = 0;
                        m_acks++;
                        if (m_acks == pkts(m_mode)) begin
                            if (m_pidx + 1 < m_passes) begin
                                ph = PH_NEXT; e_cont = 1; m_pidx++; m_acks = 0;
                            end else begin
                                ph = PH_DONE; e_done = 1;
                            end
                        end
                    end else if (TO_EN) begin
                        m_idle++;
                        if (m_idle == TO) begin
                            ph = PH_IDLE; e_to = 1; m_pidx = 0; m_acks = 0;
                        end
                    end
                end
                PH_NEXT: ph = PH_LOAD;
                PH_DONE: begin ph = PH_IDLE; m_pidx = 0; m_acks = 0; end
                default: ph = PH_IDLE;
            endcase
        end
    endtask

    function automatic logic [12:0] mkexp(input op_stage_t s, input bit b, c, n, d, t,
                                          input op_mode_t m, input int p);
        return {s, b, c, n, d, t, m, 4'(p)};
    endfunction

    function automatic logic [12:0] exp_vec();
        op_stage_t s;
        s = (ph == PH_LOAD) ? LOAD :
            (ph == PH_CONV || ph == PH_NEXT || ph == PH_DONE) ? CONV : IDLE;
        return mkexp(s, ph != PH_IDLE, e_chg, e_cont, e_done, e_to, m_mode, m_pidx);
    endfunction

    function automatic logic [12:0] act_vec();
        return {op_stage, busy, change_mode, conv_continue, done, timeout_err, mode_out, pass_idx};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_tally();
        n_chg = 0; n_cont = 0; n_done = 0; n_to = 0; n_load = 0;
        last_ack_cyc = -100; done_cyc = -1; pidx_mask = 0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input bit st, ab, input op_mode_t m, input int pn, input bit ld, ack);
        start = st; abort = ab; mode_cfg = m; pass_num = PW'(pn);
        load_done = ld; psum_ack = ack;
        if (ack && !ab && ph == PH_CONV) last_ack_cyc = cyc;
        @(posedge clk);
        model_clock(st, ab, m, pn, ld, ack);
        cyc++;
        #1;
        check("cycle", act_vec(), exp_vec());
        if (change_mode)   n_chg++;
        if (conv_continue) n_cont++;
        if (done) begin n_done++; done_cyc = cyc; end
        if (timeout_err)   n_to++;
        if (op_stage == LOAD) begin
            if (!prev_load) n_load++;
            pidx_mask = pidx_mask | (1 << pass_idx);
        end
        prev_load = (op_stage == LOAD);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, MODE1, 1, 0, 0);
    endtask

    task automatic run_layer(input op_mode_t m, input int pn, input int gap, input bit gap_ack,
                             input int mid_k);
        int passes;
        op_mode_t other;
        passes = (pn == 0) ? 1 : pn;
        other  = (m == MODE4) ? MODE1 : MODE4;
        step(1, 0, m, pn, 0, 0);
        step(0, 0, m, pn, 0, 0);
        for (int p = 0; p < passes; p++) begin
            for (int g = 0; g < gap; g++) step(0, 0, m, pn, 0, gap_ack);
            step(0, 0, m, pn, 1, 0);
            for (int k = 0; k < pkts(m); k++) begin
                if (k == mid_k) step(1, 0, other, 7, 0, 1);
                else            step(0, 0, m, pn, 0, 1);
            end
            step(0, 0, m, pn, 0, 0);
        end
    endtask

    typedef struct {
        bit          st, ab;
        op_mode_t    m;
        int          pn;
        bit          ld, ack;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit st, ab, ld, ack;
        int idle_n;
        bit seen;

        tbl[0] = '{0, 0, MODE1, 1, 0, 0, mkexp(IDLE, 0, 0, 0, 0, 0, MODE1, 0)};
        tbl[1] = '{1, 0, MODE3, 2, 0, 0, mkexp(IDLE, 1, 1, 0, 0, 0, MODE3, 0)};
        tbl[2] = '{0, 0, MODE1, 1, 0, 1, mkexp(LOAD, 1, 0, 0, 0, 0, MODE3, 0)};
        tbl[3] = '{0, 0, MODE1, 1, 0, 1, mkexp(LOAD, 1, 0, 0, 0, 0, MODE3, 0)};
        tbl[4] = '{1, 0, MODE2, 5, 0, 0, mkexp(LOAD, 1, 0, 0, 0, 0, MODE3, 0)};
        tbl[5] = '{0, 0, MODE1, 1, 1, 0, mkexp(CONV, 1, 0, 0, 0, 0, MODE3, 0)};
        tbl[6] = '{0, 0, MODE1, 1, 1, 1, mkexp(CONV, 1, 0, 0, 0, 0, MODE3, 0)};
        tbl[7] = '{1, 1, MODE1, 1, 0, 0, mkexp(IDLE, 0, 0, 0, 0, 0, MODE3, 0)};
        tbl[8] = '{1, 1, MODE4, 3, 0, 0, mkexp(IDLE, 0, 0, 0, 0, 0, MODE3, 0)};
        tbl[9] = '{0, 0, MODE1, 1, 0, 0, mkexp(IDLE, 0, 0, 0, 0, 0, MODE3, 0)};

        model_reset();
        clear_tally();
        prev_load = 0;
        rst_n = 1'b0; start = 0; abort = 0; mode_cfg = MODE2; pass_num = '0;
        load_done = 0; psum_ack = 0;
        #3;
        check("reset", act_vec(), mkexp(IDLE, 0, 0, 0, 0, 0, MODE1, 0));
        #4 rst_n = 1'b1;

        // table: start/ignored inputs/abort corners
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].st, tbl[i].ab, tbl[i].m, tbl[i].pn, tbl[i].ld, tbl[i].ack);
            check($sformatf("vec%0d", i), act_vec(), tbl[i].exp);
        end

        // 1: MODE1 single pass
        clear_tally();
        run_layer(MODE1, 1, 1, 0, -1);
        check("t1_chg", n_chg, 1);
        check("t1_cont", n_cont, 0);
        check("t1_done", n_done, 1);
        check("t1_done_gap", done_cyc - last_ack_cyc, 1);

        // 2: MODE4 three passes
        clear_tally();
        run_layer(MODE4, 3, 0, 0, -1);
        check("t2_cont", n_cont, 2);
        check("t2_load_entries", n_load, 3);
        check("t2_pass_seen", pidx_mask, 7);
        check("t2_done", n_done, 1);
        check("t2_done_gap", done_cyc - last_ack_cyc, 1);

        // 3: acks held during LOAD are not counted
        clear_tally();
        run_layer(MODE3, 1, 5, 1, -1);
        check("t3_done", n_done, 1);
        check("t3_done_gap", done_cyc - last_ack_cyc, 1);

        // 4: pass_num 0 -> one pass; start mid-CONV ignored
        clear_tally();
        run_layer(MODE2, 0, 0, 0, 5);
        check("t4_cont", n_cont, 0);
        check("t4_done", n_done, 1);
        check("t4_mode", mode_out, MODE2);

        // 5: abort+start in CONV after 7 acks, then a clean layer
        clear_tally();
        step(1, 0, MODE1, 2, 0, 0);
        step(0, 0, MODE1, 2, 0, 0);
        step(0, 0, MODE1, 2, 1, 0);
        for (int k = 0; k < 7; k++) step(0, 0, MODE1, 2, 0, 1);
        step(1, 1, MODE3, 1, 0, 0);
        check("t5_busy", busy, 0);
        check("t5_pidx", pass_idx, 0);
        check("t5_mode", mode_out, MODE1);
        idle(3);
        check("t5_no_done", n_done, 0);
        run_layer(MODE3, 2, 0, 0, -1);
        check("t5_cont", n_cont, 1);
        check("t5_done", n_done, 1);

        // async reset in the middle of CONV
        step(1, 0, MODE4, 2, 0, 0);
        step(0, 0, MODE4, 2, 0, 0);
        step(0, 0, MODE4, 2, 1, 0);
        for (int k = 0; k < 5; k++) step(0, 0, MODE4, 2, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", act_vec(), mkexp(IDLE, 0, 0, 0, 0, 0, MODE1, 0));
        model_reset();
        prev_load = 0;
        #2 rst_n = 1'b1;
        idle(2);

        // 6: no acks in CONV
        clear_tally();
        step(1, 0, MODE1, 1, 0, 0);
        step(0, 0, MODE1, 1, 0, 0);
        step(0, 0, MODE1, 1, 1, 0);
        idle_n = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            idle(1);
            idle_n++;
            if (timeout_err) seen = 1;
        end
`ifdef CONV_TIMEOUT_EN
        check("t6_timeout_cycle", idle_n, TO);
        check("t6_busy", busy, 0);
        check("t6_stage", op_stage, IDLE);
        check("t6_no_done", n_done, 0);
`else
        check("t6_no_timeout", seen, 0);
        check("t6_stage", op_stage, CONV);
        check("t6_busy", busy, 1);
        step(0, 1, MODE1, 1, 0, 0);
`endif
        idle(2);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            st  = ($urandom_range(0, 9) == 0);
            ab  = ($urandom_range(0, 79) == 0);
            ld  = ($urandom_range(0, 2) == 0);
            ack = ($urandom_range(0, 9) < 8);
            step(st, ab, op_mode_t'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ld, ack);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
